// File: rtl/cdb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : cdb_arbiter
//  Purpose  : Shares the common data bus among NUM_EXU execution units.
//             Combinational one-hot grant over the exu req/rdy handshake,
//             registered single-cycle CDB broadcast (wr/tag/wdata/inst_id).
//             Default arbitration is round-robin; defining the macro
//             CDB_AGE_PRIO_EN switches to oldest-in-program-order priority
//             relative to rob_head (ties go to the lowest index).
//  Revision : 1.0 - initial release
// ============================================================================
module cdb_arbiter #(
    parameter int NUM_EXU   = 4,
    parameter int TAG_W     = 4,
    parameter int ROB_DEPTH = 16,
    parameter int ROB_PTR_W = $clog2(ROB_DEPTH)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic [ROB_PTR_W-1:0]         rob_head,
    input  logic [NUM_EXU-1:0]           exu_req,
    output logic [NUM_EXU-1:0]           exu_rdy,
    input  logic [NUM_EXU*TAG_W-1:0]     exu_tag,
    input  logic [NUM_EXU*32-1:0]        exu_wdata,
    input  logic [NUM_EXU*ROB_PTR_W-1:0] exu_inst_id,
    output logic                         cdb_wr,
    output logic [TAG_W-1:0]             cdb_tag,
    output logic [31:0]                  cdb_wdata,
    output logic [ROB_PTR_W-1:0]         cdb_inst_id
);

    localparam int c_idx_w = (NUM_EXU > 1) ? $clog2(NUM_EXU) : 1;

    // Winner of this cycle's arbitration, before flush gating
    logic                 w_found;
    logic [c_idx_w-1:0]   w_sel_idx;
    logic [NUM_EXU-1:0]   w_grant;
    logic                 w_xfer;
    logic [TAG_W-1:0]     w_sel_tag;
    logic [31:0]          w_sel_wdata;
    logic [ROB_PTR_W-1:0] w_sel_inst_id;

    logic                 r_cdb_wr;
    logic [TAG_W-1:0]     r_cdb_tag;
    logic [31:0]          r_cdb_wdata;
    logic [ROB_PTR_W-1:0] r_cdb_inst_id;

`ifdef CDB_AGE_PRIO_EN

    localparam int                 c_age_w     = ROB_PTR_W + 1;
    localparam logic [c_age_w-1:0] c_rob_depth = c_age_w'(ROB_DEPTH);

    // Distance of each requester from the commit pointer, modulo ROB_DEPTH
    logic [c_age_w-1:0] w_age [NUM_EXU];
    logic [c_age_w-1:0] w_best_age;

    for (genvar gi = 0; gi < NUM_EXU; gi++) begin : g_age
        logic [c_age_w-1:0] w_diff;
        // Bias by ROB_DEPTH so the subtraction never goes negative
        assign w_diff = {1'b0, exu_inst_id[gi*ROB_PTR_W +: ROB_PTR_W]}
                      + c_rob_depth - {1'b0, rob_head};
        assign w_age[gi] = (w_diff >= c_rob_depth) ? (w_diff - c_rob_depth) : w_diff;
    end

    // Pick the smallest age; strict compare keeps the lowest index on ties
    always_comb begin
        w_found    = 1'b0;
        w_sel_idx  = '0;
        w_best_age = '0;
        for (int i = 0; i < NUM_EXU; i++) begin
            if (exu_req[i] && (!w_found || (w_age[i] < w_best_age))) begin
                w_found    = 1'b1;
                w_best_age = w_age[i];
                w_sel_idx  = c_idx_w'(i);
            end
        end
    end

`else

    localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(NUM_EXU - 1);

    logic [c_idx_w-1:0] r_rr_ptr;
    logic               w_unused_rob_head;

    // rob_head only matters for age-based priority
    assign w_unused_rob_head = ^rob_head;

    // Index reached after stepping k places past base, wrapping at NUM_EXU
    function automatic logic [c_idx_w-1:0] rr_index(input logic [c_idx_w-1:0] base,
                                                    input int                 k);
        int sum;
        sum = int'(base) + k;
        if (sum >= NUM_EXU) begin
            sum = sum - NUM_EXU;
        end
        return c_idx_w'(sum);
    endfunction

    // First requester at or after the round-robin pointer wins
    always_comb begin
        w_found   = 1'b0;
        w_sel_idx = '0;
        for (int k = 0; k < NUM_EXU; k++) begin
            if (!w_found && exu_req[rr_index(r_rr_ptr, k)]) begin
                w_found   = 1'b1;
                w_sel_idx = rr_index(r_rr_ptr, k);
            end
        end
    end

    // Pointer moves just past the EXU that completed a transfer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr <= '0;
        end else if (w_xfer) begin
            r_rr_ptr <= (w_sel_idx == c_last_idx) ? '0 : (w_sel_idx + 1'b1);
        end
    end

`endif

    // A flush squashes the grant so no EXU believes its result was taken
    assign w_xfer = w_found && !flush;

    // One-hot grant vector driven straight back to the EXUs
    always_comb begin
        w_grant = '0;
        if (w_xfer) begin
            w_grant[w_sel_idx] = 1'b1;
        end
    end

    assign exu_rdy = w_grant;

    assign w_sel_tag     = exu_tag[int'(w_sel_idx)*TAG_W +: TAG_W];
    assign w_sel_wdata   = exu_wdata[int'(w_sel_idx)*32 +: 32];
    assign w_sel_inst_id = exu_inst_id[int'(w_sel_idx)*ROB_PTR_W +: ROB_PTR_W];

    // Broadcast register: valid pulses per transfer, payload holds otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cdb_wr      <= 1'b0;
            r_cdb_tag     <= '0;
            r_cdb_wdata   <= '0;
            r_cdb_inst_id <= '0;
        end else begin
            r_cdb_wr <= w_xfer;
            if (w_xfer) begin
                r_cdb_tag     <= w_sel_tag;
                r_cdb_wdata   <= w_sel_wdata;
                r_cdb_inst_id <= w_sel_inst_id;
            end
        end
    end

    assign cdb_wr      = r_cdb_wr;
    assign cdb_tag     = r_cdb_tag;
    assign cdb_wdata   = r_cdb_wdata;
    assign cdb_inst_id = r_cdb_inst_id;

endmodule
`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cdb_arbiter
//  Purpose  : Self-checking bench for cdb_arbiter (round-robin build):
//             directed vector table, reset-in-flight sequence, then random
//             EXU traffic against a queue-style reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cdb_arbiter;

    localparam int N   = 4;
    localparam int TW  = 4;
    localparam int PW  = 4;
    localparam int RND = 2000;

    logic          clk;
    logic          rst_n;
    logic          flush;
    logic [PW-1:0] rob_head;
    logic [N-1:0]  exu_req;
    logic [N-1:0]  exu_rdy;
    logic [N*TW-1:0] exu_tag;
    logic [N*32-1:0] exu_wdata;
    logic [N*PW-1:0] exu_inst_id;
    logic          cdb_wr;
    logic [TW-1:0] cdb_tag;
    logic [31:0]   cdb_wdata;
    logic [PW-1:0] cdb_inst_id;

    cdb_arbiter #(
        .NUM_EXU   (N),
        .TAG_W     (TW),
        .ROB_DEPTH (16),
        .ROB_PTR_W (PW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .rob_head    (rob_head),
        .exu_req     (exu_req),
        .exu_rdy     (exu_rdy),
        .exu_tag     (exu_tag),
        .exu_wdata   (exu_wdata),
        .exu_inst_id (exu_inst_id),
        .cdb_wr      (cdb_wr),
        .cdb_tag     (cdb_tag),
        .cdb_wdata   (cdb_wdata),
        .cdb_inst_id (cdb_inst_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Per-EXU result currently being presented
    logic [TW-1:0] pay_tag  [N];
    logic [31:0]   pay_data [N];
    logic [PW-1:0] pay_id   [N];

    typedef struct {
        logic [N-1:0] req;
        logic         flush;
        logic [N-1:0] exp_rdy;
        logic         exp_wr;
        int           exp_src;   // EXU whose payload the CDB should hold; -1 = reset zeros
    } vec_t;

    vec_t tbl [25];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive_payload();
        for (int i = 0; i < N; i++) begin
            exu_tag[i*TW +: TW]     = pay_tag[i];
            exu_wdata[i*32 +: 32]   = pay_data[i];
            exu_inst_id[i*PW +: PW] = pay_id[i];
        end
    endtask

    task automatic check_cdb(input string tag_name, input int src);
        if (src < 0) begin
            check({tag_name, ".tag"},  32'(cdb_tag),     32'd0);
            check({tag_name, ".data"}, cdb_wdata,        32'd0);
            check({tag_name, ".id"},   32'(cdb_inst_id), 32'd0);
        end else begin
            check({tag_name, ".tag"},  32'(cdb_tag),     32'(pay_tag[src]));
            check({tag_name, ".data"}, cdb_wdata,        pay_data[src]);
            check({tag_name, ".id"},   32'(cdb_inst_id), 32'(pay_id[src]));
        end
    endtask

    // Random-phase reference state
    int            m_ptr;
    logic          m_wr;
    logic [TW-1:0] m_tag;
    logic [31:0]   m_data;
    logic [PW-1:0] m_id;
    bit            pending [N];
    int            wait_cnt[N];

    initial begin
        rst_n       = 1'b0;
        flush       = 1'b0;
        rob_head    = '0;
        exu_req     = '0;
        exu_tag     = '0;
        exu_wdata   = '0;
        exu_inst_id = '0;

        pay_tag[0] = 4'd1; pay_data[0] = 32'h1000_0001; pay_id[0] = 4'd8;
        pay_tag[1] = 4'd2; pay_data[1] = 32'h2222_1111; pay_id[1] = 4'd9;
        pay_tag[2] = 4'd3; pay_data[2] = 32'hDEAD_BEEF; pay_id[2] = 4'd5;
        pay_tag[3] = 4'd4; pay_data[3] = 32'h3333_CAFE; pay_id[3] = 4'd11;
        drive_payload();

        for (int i = 0; i < 5; i++) tbl[i] = '{4'b0000, 1'b0, 4'b0000, 1'b0, -1};
        tbl[5]  = '{4'b0100, 1'b0, 4'b0100, 1'b1, 2};
        tbl[6]  = '{4'b1111, 1'b0, 4'b1000, 1'b1, 3};
        tbl[7]  = '{4'b1111, 1'b0, 4'b0001, 1'b1, 0};
        tbl[8]  = '{4'b1111, 1'b0, 4'b0010, 1'b1, 1};
        tbl[9]  = '{4'b1111, 1'b0, 4'b0100, 1'b1, 2};
        tbl[10] = '{4'b1111, 1'b0, 4'b1000, 1'b1, 3};
        tbl[11] = '{4'b1111, 1'b0, 4'b0001, 1'b1, 0};
        tbl[12] = '{4'b1111, 1'b0, 4'b0010, 1'b1, 1};
        tbl[13] = '{4'b1111, 1'b0, 4'b0100, 1'b1, 2};
        tbl[14] = '{4'b1111, 1'b0, 4'b1000, 1'b1, 3};
        tbl[15] = '{4'b0100, 1'b0, 4'b0100, 1'b1, 2};
        tbl[16] = '{4'b1001, 1'b0, 4'b1000, 1'b1, 3};
        tbl[17] = '{4'b1001, 1'b0, 4'b0001, 1'b1, 0};
        tbl[18] = '{4'b0011, 1'b1, 4'b0000, 1'b0, 0};
        tbl[19] = '{4'b0011, 1'b0, 4'b0010, 1'b1, 1};
        tbl[20] = '{4'b0011, 1'b0, 4'b0001, 1'b1, 0};
        tbl[21] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 0};
        tbl[22] = '{4'b0010, 1'b0, 4'b0010, 1'b1, 1};
        tbl[23] = '{4'b0010, 1'b0, 4'b0010, 1'b1, 1};
        tbl[24] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 1};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset.wr",  32'(cdb_wr),  32'd0);
        check("reset.rdy", 32'(exu_rdy), 32'd0);
        check_cdb("reset", -1);
        rst_n = 1'b1;

        // Directed vector table
        for (int v = 0; v < 25; v++) begin
            exu_req = tbl[v].req;
            flush   = tbl[v].flush;
            @(negedge clk);
            check($sformatf("vec%0d.rdy", v), 32'(exu_rdy), 32'(tbl[v].exp_rdy));
            @(posedge clk);
            #1;
            check($sformatf("vec%0d.wr", v), 32'(cdb_wr), 32'(tbl[v].exp_wr));
            check_cdb($sformatf("vec%0d", v), tbl[v].exp_src);
        end

        // Reset arriving with a broadcast in flight (pointer sits at 2 here)
        exu_req = 4'b1111;
        flush   = 1'b0;
        @(negedge clk);
        check("midrst.pre_rdy", 32'(exu_rdy), 32'b0100);
        @(posedge clk);
        #1;
        check("midrst.pre_wr", 32'(cdb_wr), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst.wr",  32'(cdb_wr),  32'd0);
        check("midrst.rdy", 32'(exu_rdy), 32'b0001);
        check_cdb("midrst", -1);
        exu_req = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Random traffic against the reference model
        m_ptr = 0; m_wr = 1'b0; m_tag = '0; m_data = '0; m_id = '0;
        for (int i = 0; i < N; i++) begin
            pending[i]  = 1'b0;
            wait_cnt[i] = 0;
        end
        for (int c = 0; c < RND; c++) begin
            int g;
            for (int i = 0; i < N; i++) begin
                if (!pending[i] && ($urandom_range(0, 99) < 60)) begin
                    pending[i]  = 1'b1;
                    wait_cnt[i] = 0;
                    pay_tag[i]  = TW'($urandom);
                    pay_data[i] = $urandom;
                    pay_id[i]   = PW'($urandom);
                end
                exu_req[i] = pending[i];
            end
            flush    = ($urandom_range(0, 99) < 8);
            rob_head = PW'($urandom);
            drive_payload();

            g = -1;
            if (!flush) begin
                for (int k = 0; k < N; k++) begin
                    if (g < 0 && pending[(m_ptr + k) % N]) g = (m_ptr + k) % N;
                end
            end

            @(negedge clk);
            check("rnd.rdy", 32'(exu_rdy), (g >= 0) ? (32'd1 << g) : 32'd0);
            @(posedge clk);
            if (g >= 0) begin
                m_wr   = 1'b1;
                m_tag  = pay_tag[g];
                m_data = pay_data[g];
                m_id   = pay_id[g];
                m_ptr  = (g + 1) % N;
                check("rnd.fair", 32'(wait_cnt[g] < N), 32'd1);
                pending[g] = 1'b0;
            end else begin
                m_wr = 1'b0;
            end
            for (int i = 0; i < N; i++) begin
                if (pending[i] && !flush) wait_cnt[i]++;
            end
            #1;
            check("rnd.wr",   32'(cdb_wr),      32'(m_wr));
            check("rnd.tag",  32'(cdb_tag),     32'(m_tag));
            check("rnd.data", cdb_wdata,        m_data);
            check("rnd.id",   32'(cdb_inst_id), 32'(m_id));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Watchdog so the run always ends
    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
